// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM states, level constants and bank-strobe encoding for the
// interrupt context sequencer.
package irq_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SAVE,
        ST_VECTOR,
        ST_RESTORE,
        ST_WAIT,
        ST_RESUME
    } state_e;

    localparam logic [1:0] LVL_USER = 2'd0;
    localparam logic [1:0] LVL_1    = 2'd1;
    localparam logic [1:0] LVL_2    = 2'd2;
    localparam logic [1:0] LVL_3    = 2'd3;

    localparam logic [2:0] BANK_USER = 3'b001;
    localparam logic [2:0] BANK_1    = 3'b010;
    localparam logic [2:0] BANK_2    = 3'b100;
    localparam logic [2:0] BANK_NONE = 3'b000;

    // Level 3 never gets preempted, so it owns no bank.
    function automatic logic [2:0] bank_sel(input logic [1:0] lvl);
        return (lvl == LVL_USER) ? BANK_USER :
               (lvl == LVL_1)    ? BANK_1    :
               (lvl == LVL_2)    ? BANK_2    : BANK_NONE;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: rising-edge detect on the interrupt lines, pending latch and
// highest-level priority encoder.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] irq_in,
    input  logic [2:0] clr,
    output logic [2:0] pending,
    output logic [1:0] new_lvl,
    output logic       valid
);

    logic [2:0] irq_prev_q, irq_prev_d;
    logic [2:0] pending_q, pending_d;

    // A fresh edge in the same cycle as the service clear keeps the bit set.
    always_comb begin
        irq_prev_d = irq_in;
        pending_d  = (pending_q & ~clr) | (irq_in & ~irq_prev_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
        end
    end

    assign pending = pending_q;
    assign valid   = |pending_q;
    assign new_lvl = pending_q[2] ? LVL_3 : pending_q[1] ? LVL_2 : pending_q[0] ? LVL_1 : LVL_USER;

endmodule

// File: rtl/irq_ctx_ctrl.sv
// irq_ctx_ctrl: nested interrupt entry/return sequencer driving register-bank
// save/restore strobes and the PC redirect.
module irq_ctx_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] VEC1         = 32'h0000_1000,
    parameter logic [31:0] VEC2         = 32'h0000_1100,
    parameter logic [31:0] VEC3         = 32'h0000_1200,
    parameter int unsigned RESTORE_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  irq_in,
    input  logic        global_ie,
    input  logic        insn_done,
    input  logic [31:0] pc_next,
    input  logic        eret,
    output logic        enable_userBackUp,
    output logic        enable_BackUp1,
    output logic        enable_BackUp2,
    output logic        restore_userBackUp,
    output logic        restore_BackUp1,
    output logic        restore_BackUp2,
    output logic        stall,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic [1:0]  cur_level,
    output logic [2:0]  pending,
    output logic        err_eret
);

    state_e      state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  cur_q, cur_d;
    logic [31:0] epc_q [4];
    logic [31:0] epc_d [4];
    logic [1:0]  prev_q [4];
    logic [1:0]  prev_d [4];
    logic [2:0]  save_q, save_d, rest_q, rest_d;
    logic        stall_q, stall_d, load_q, load_d, err_q, err_d;
    logic [31:0] tgt_pc_q, tgt_pc_d;
    logic [2:0]  clr;
    logic [1:0]  new_lvl;
    logic        valid, go_res;

    irq_prio_enc u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_in  (irq_in),
        .clr     (clr),
        .pending (pending),
        .new_lvl (new_lvl),
        .valid   (valid)
    );

    // Level n's pending bit sits at bit n-1, the same one-hot as bank n-1.
    assign clr    = (state_q == ST_SAVE) ? bank_sel(tgt_q - 2'd1) : 3'b000;
    assign go_res = (state_q == ST_RESTORE && RESTORE_WAIT == 0) || (state_q == ST_WAIT && cnt_q == 3'd0);

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        epc_d    = epc_q;
        prev_d   = prev_q;
        save_d   = 3'b000;
        rest_d   = 3'b000;
        stall_d  = 1'b0;
        load_d   = 1'b0;
        err_d    = 1'b0;
        tgt_pc_d = tgt_pc_q;
        case (state_q)
            ST_RUN: begin
                if (insn_done && eret) begin
                    if (cur_q == LVL_USER) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RESTORE;
                        tgt_d   = prev_q[cur_q];
                        rest_d  = bank_sel(prev_q[cur_q]);
                        stall_d = 1'b1;
                    end
                end else if (insn_done && global_ie && valid && new_lvl > cur_q) begin
                    state_d         = ST_SAVE;
                    tgt_d           = new_lvl;
                    epc_d[cur_q]    = pc_next;
                    prev_d[new_lvl] = cur_q;
                    save_d          = bank_sel(cur_q);
                    stall_d         = 1'b1;
                end
            end
            ST_SAVE: begin
                state_d  = ST_VECTOR;
                stall_d  = 1'b1;
                load_d   = 1'b1;
                tgt_pc_d = (tgt_q == LVL_1) ? VEC1 : (tgt_q == LVL_2) ? VEC2 : VEC3;
                cur_d    = tgt_q;
            end
            ST_RESTORE: begin
                state_d = ST_WAIT;
                cnt_d   = 3'(RESTORE_WAIT - 1);
                stall_d = 1'b1;
            end
            ST_WAIT: begin
                cnt_d   = cnt_q - 3'd1;
                stall_d = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        if (go_res) begin
            state_d  = ST_RESUME;
            load_d   = 1'b1;
            tgt_pc_d = epc_q[tgt_q];
            cur_d    = tgt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            tgt_q    <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            epc_q    <= '{default: '0};
            prev_q   <= '{default: '0};
            save_q   <= '0;
            rest_q   <= '0;
            stall_q  <= 1'b0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            tgt_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            epc_q    <= epc_d;
            prev_q   <= prev_d;
            save_q   <= save_d;
            rest_q   <= rest_d;
            stall_q  <= stall_d;
            load_q   <= load_d;
            err_q    <= err_d;
            tgt_pc_q <= tgt_pc_d;
        end
    end

    assign {enable_BackUp2, enable_BackUp1, enable_userBackUp}    = save_q;
    assign {restore_BackUp2, restore_BackUp1, restore_userBackUp} = rest_q;
    assign stall     = stall_q;
    assign pc_load   = load_q;
    assign pc_target = tgt_pc_q;
    assign cur_level = cur_q;
    assign err_eret  = err_q;

endmodule

// File: tb/tb_irq_ctx_ctrl.sv
// tb_irq_ctx_ctrl: directed vector table for the nesting scenarios, an async
// reset sequence, then random stimulus against a transaction-queue model.
module tb_irq_ctx_ctrl;

    localparam int          RW = 1;
    localparam logic [31:0] V1 = 32'h0000_1000;
    localparam logic [31:0] V2 = 32'h0000_1100;
    localparam logic [31:0] V3 = 32'h0000_1200;

    logic        clk, rst_n;
    logic [2:0]  irq_in;
    logic        global_ie, insn_done, eret;
    logic [31:0] pc_next;
    logic        enable_userBackUp, enable_BackUp1, enable_BackUp2;
    logic        restore_userBackUp, restore_BackUp1, restore_BackUp2;
    logic        stall, pc_load, err_eret;
    logic [31:0] pc_target;
    logic [1:0]  cur_level;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    irq_ctx_ctrl #(.VEC1(V1), .VEC2(V2), .VEC3(V3), .RESTORE_WAIT(RW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .irq_in             (irq_in),
        .global_ie          (global_ie),
        .insn_done          (insn_done),
        .pc_next            (pc_next),
        .eret               (eret),
        .enable_userBackUp  (enable_userBackUp),
        .enable_BackUp1     (enable_BackUp1),
        .enable_BackUp2     (enable_BackUp2),
        .restore_userBackUp (restore_userBackUp),
        .restore_BackUp1    (restore_BackUp1),
        .restore_BackUp2    (restore_BackUp2),
        .stall              (stall),
        .pc_load            (pc_load),
        .pc_target          (pc_target),
        .cur_level          (cur_level),
        .pending            (pending),
        .err_eret           (err_eret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  irq;
        logic        ie, done, ret;
        logic [31:0] pc;
        logic [2:0]  save, rest;
        logic        stall, load;
        logic [31:0] tgt;
        logic [1:0]  lvl;
        logic [2:0]  pend;
        logic        err;
    } vec_t;

    typedef struct {
        logic [2:0]  save, rest;
        logic        load;
        logic [31:0] tgt;
        logic [1:0]  lvl;
        logic [2:0]  clr;
    } rec_t;

    vec_t tbl[$];
    rec_t plan[$];

    function automatic vec_t v(input logic [2:0] irq, input logic ie, input logic done, input logic ret,
                               input logic [31:0] pc, input logic [2:0] save, input logic [2:0] rest,
                               input logic stl, input logic load, input logic [31:0] tgt,
                               input logic [1:0] lvl, input logic [2:0] pend, input logic err);
        vec_t r;
        r.irq = irq; r.ie = ie; r.done = done; r.ret = ret; r.pc = pc;
        r.save = save; r.rest = rest; r.stall = stl; r.load = load; r.tgt = tgt;
        r.lvl = lvl; r.pend = pend; r.err = err;
        return r;
    endfunction

    function automatic vec_t idle(input logic [1:0] lvl, input logic [2:0] pend);
        return v(3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0, lvl, pend, 1'b0);
    endfunction

    function automatic vec_t stl(input logic [1:0] lvl, input logic [2:0] pend);
        return v(3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 32'd0, lvl, pend, 1'b0);
    endfunction

    function automatic vec_t jmp(input logic [31:0] tgt, input logic [1:0] lvl, input logic [2:0] pend);
        return v(3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, tgt, lvl, pend, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic out_chk(input string t, input vec_t e);
        chk({t, " save"}, 32'({enable_BackUp2, enable_BackUp1, enable_userBackUp}), 32'(e.save));
        chk({t, " restore"}, 32'({restore_BackUp2, restore_BackUp1, restore_userBackUp}), 32'(e.rest));
        chk({t, " stall"}, 32'(stall), 32'(e.stall));
        chk({t, " pc_load"}, 32'(pc_load), 32'(e.load));
        if (e.load) chk({t, " pc_target"}, pc_target, e.tgt);
        chk({t, " cur_level"}, 32'(cur_level), 32'(e.lvl));
        chk({t, " pending"}, 32'(pending), 32'(e.pend));
        chk({t, " err_eret"}, 32'(err_eret), 32'(e.err));
    endtask

    task automatic apply(input vec_t r);
        irq_in = r.irq; global_ie = r.ie; insn_done = r.done; eret = r.ret; pc_next = r.pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] top_lvl(input logic [2:0] p);
        for (int k = 2; k >= 0; k--) if (p[k]) return 2'(k + 1);
        return 2'd0;
    endfunction

    logic [1:0]  m_lvl;
    logic [2:0]  m_pend, m_irq_prev;
    logic        m_busy;
    logic [31:0] m_epc [4];
    logic [1:0]  m_prev [4];

    initial begin
        vec_t e;
        rec_t o, w;
        logic [1:0] p, n;
        rst_n = 1'b0;
        apply(idle(2'd0, 3'd0));
        global_ie = 1'b0;
        step();
        step();
        out_chk("reset", v(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 2'd0, 3'd0, 1'b0));
        chk("reset pc_target", pc_target, 32'd0);
        rst_n = 1'b1;

        // entry from user
        tbl.push_back(v(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd1, 0));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h40, 3'd1, 0, 1, 0, 0, 2'd0, 3'd1, 0));
        tbl.push_back(jmp(V1, 2'd1, 3'd0));
        tbl.push_back(idle(2'd1, 3'd0));
        // nest to level 3 and unwind twice
        tbl.push_back(v(3'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 3'd4, 0));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h1008, 3'd2, 0, 1, 0, 0, 2'd1, 3'd4, 0));
        tbl.push_back(jmp(V3, 2'd3, 3'd0));
        tbl.push_back(idle(2'd3, 3'd0));
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 3'd2, 1, 0, 0, 2'd3, 3'd0, 0));
        tbl.push_back(stl(2'd3, 3'd0));
        tbl.push_back(jmp(32'h1008, 2'd1, 3'd0));
        tbl.push_back(idle(2'd1, 3'd0));
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 3'd1, 1, 0, 0, 2'd1, 3'd0, 0));
        tbl.push_back(stl(2'd1, 3'd0));
        tbl.push_back(jmp(32'h40, 2'd0, 3'd0));
        tbl.push_back(idle(2'd0, 3'd0));
        // lower request blocked at level 2, taken after return
        tbl.push_back(v(3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd2, 0));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h80, 3'd1, 0, 1, 0, 0, 2'd0, 3'd2, 0));
        tbl.push_back(jmp(V2, 2'd2, 3'd0));
        tbl.push_back(v(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 3'd1, 0));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h1104, 0, 0, 0, 0, 0, 2'd2, 3'd1, 0));
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 3'd1, 1, 0, 0, 2'd2, 3'd1, 0));
        tbl.push_back(stl(2'd2, 3'd1));
        tbl.push_back(jmp(32'h80, 2'd0, 3'd1));
        tbl.push_back(idle(2'd0, 3'd1));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h84, 3'd1, 0, 1, 0, 0, 2'd0, 3'd1, 0));
        tbl.push_back(jmp(V1, 2'd1, 3'd0));
        // eret and eligible interrupt together: eret first
        tbl.push_back(v(3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 3'd2, 0));
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 3'd1, 1, 0, 0, 2'd1, 3'd2, 0));
        tbl.push_back(stl(2'd1, 3'd2));
        tbl.push_back(jmp(32'h84, 2'd0, 3'd2));
        tbl.push_back(idle(2'd0, 3'd2));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h88, 3'd1, 0, 1, 0, 0, 2'd0, 3'd2, 0));
        tbl.push_back(jmp(V2, 2'd2, 3'd0));
        tbl.push_back(idle(2'd2, 3'd0));
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 3'd1, 1, 0, 0, 2'd2, 3'd0, 0));
        tbl.push_back(stl(2'd2, 3'd0));
        tbl.push_back(jmp(32'h88, 2'd0, 3'd0));
        tbl.push_back(idle(2'd0, 3'd0));
        // eret at user level, then global_ie gating
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1));
        tbl.push_back(idle(2'd0, 3'd0));
        tbl.push_back(v(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd4, 0));
        tbl.push_back(v(3'd0, 0, 1, 0, 32'h90, 0, 0, 0, 0, 0, 2'd0, 3'd4, 0));
        tbl.push_back(idle(2'd0, 3'd4));
        tbl.push_back(v(3'd0, 1, 1, 0, 32'h94, 3'd1, 0, 1, 0, 0, 2'd0, 3'd4, 0));
        tbl.push_back(jmp(V3, 2'd3, 3'd0));
        tbl.push_back(idle(2'd3, 3'd0));
        tbl.push_back(v(3'd0, 1, 1, 1, 0, 0, 3'd1, 1, 0, 0, 2'd3, 3'd0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            step();
            out_chk($sformatf("row%0d", i), tbl[i]);
        end

        // async reset while in WAIT abandons the return
        apply(idle(2'd3, 3'd0));
        step();
        out_chk("wait", stl(2'd3, 3'd0));
        #2 rst_n = 1'b0;
        #1;
        out_chk("midreset", v(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0));
        chk("midreset pc_target", pc_target, 32'd0);
        rst_n = 1'b1;
        apply(v(3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd2, 0));
        step();
        out_chk("post pend", v(3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd2, 0));
        apply(v(3'd0, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 2'd0, 3'd2, 0));
        step();
        out_chk("post save", v(3'd0, 1, 1, 0, 0, 3'd1, 0, 1, 0, 0, 2'd0, 3'd2, 0));
        apply(idle(2'd0, 3'd0));
        step();
        out_chk("post vector", jmp(V2, 2'd2, 3'd0));

        // random phase against the transaction-queue model
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_lvl = 2'd0; m_pend = 3'd0; m_irq_prev = 3'd0; m_busy = 1'b0;
        m_epc = '{default: '0};
        m_prev = '{default: '0};
        plan.delete();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom);
            insn_done = 1'($urandom);
            eret      = insn_done && ($urandom_range(0, 3) == 0);
            global_ie = ($urandom_range(0, 7) != 0);
            pc_next   = $urandom & 32'hffff_fffc;
            step();
            o = '{save: 3'd0, rest: 3'd0, load: 1'b0, tgt: 32'd0, lvl: m_lvl, clr: 3'd0};
            e = idle(m_lvl, 3'd0);
            if (m_busy) begin
                if (plan.size() > 0) begin
                    o = plan.pop_front();
                    e.stall = 1'b1;
                end
            end else if (insn_done && eret) begin
                if (m_lvl == 2'd0) e.err = 1'b1;
                else begin
                    p = m_prev[m_lvl];
                    o.rest = 3'(1 << p);
                    e.stall = 1'b1;
                    w = '{save: 3'd0, rest: 3'd0, load: 1'b0, tgt: 32'd0, lvl: m_lvl, clr: 3'd0};
                    repeat (RW) plan.push_back(w);
                    w.load = 1'b1; w.tgt = m_epc[p]; w.lvl = p;
                    plan.push_back(w);
                end
            end else if (insn_done && global_ie && top_lvl(m_pend) > m_lvl) begin
                n = top_lvl(m_pend);
                m_epc[m_lvl] = pc_next;
                m_prev[n] = m_lvl;
                o.save = 3'(1 << m_lvl);
                e.stall = 1'b1;
                w.save = 3'd0; w.rest = 3'd0; w.load = 1'b1; w.lvl = n;
                w.tgt = (n == 2'd1) ? V1 : (n == 2'd2) ? V2 : V3;
                w.clr = 3'(1 << (n - 2'd1));
                plan.push_back(w);
            end
            m_pend = (m_pend & ~o.clr) | (irq_in & ~m_irq_prev);
            m_irq_prev = irq_in;
            m_lvl = o.lvl;
            m_busy = e.stall;
            e.save = o.save; e.rest = o.rest; e.load = o.load; e.tgt = o.tgt;
            e.lvl = m_lvl; e.pend = m_pend;
            out_chk($sformatf("rnd%0d", c), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctx_ctrl.md
Name: irq_ctx_ctrl

Overview:
- Interrupt context sequencer for the CPU core. It owns the register-file bank controls (backup/restore strobes for the user bank, bank 1 and bank 2) and the PC redirect.
- Takes up to three prioritised interrupts with strict nesting: level 1 < level 2 < level 3, and user code is level 0.
- On entry it saves the preempted context into the bank indexed by that context's level. On `eret` it restores that bank and resumes at the saved PC.
- Sits between the interrupt sources, the PC/fetch unit and the register file.

Parameters:
- `VEC1`, 32'h0000_1000, handler address for level 1 (`irq_in[0]`)
- `VEC2`, 32'h0000_1100, handler address for level 2 (`irq_in[1]`)
- `VEC3`, 32'h0000_1200, handler address for level 3 (`irq_in[2]`)
- `RESTORE_WAIT`, 1, extra stall cycles after a restore strobe so the register-file copy settles (range 0..7)

Ports:
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `irq_in` in 3: interrupt lines; bit k is level k+1; rising edge sets pending
- `global_ie` in 1: global interrupt enable
- `insn_done` in 1: instruction boundary; `pc_next` is valid this cycle
- `pc_next` in 32: PC of the next instruction
- `eret` in 1: return-from-interrupt, one-cycle pulse, qualified by `insn_done`
- `enable_userBackUp`, `enable_BackUp1`, `enable_BackUp2` out 1 each: bank save strobes
- `restore_userBackUp`, `restore_BackUp1`, `restore_BackUp2` out 1 each: bank restore strobes
- `stall` out 1: freeze pipeline
- `pc_load` out 1: PC redirect strobe
- `pc_target` out 32: redirect address
- `cur_level` out 2: current execution level
- `pending` out 3: latched pending interrupts
- `err_eret` out 1: pulse when `eret` arrives at level 0

Behaviour:
- **Reset (async, `rst_n`=0):**
  - State RUN; `cur_level`=0; `pending`=0; irq edge registers=0.
  - `epc[0..2]`=0; `prev_lvl[1..3]`=0.
  - All strobes, `stall`, `pc_load`, `err_eret` = 0; `pc_target`=0.
  - Reset mid-sequence abandons the sequence; no strobe is completed.
- **Pending:** `pending[k]` is set on a 0→1 edge of `irq_in[k]`, sampled every cycle in every state. It is cleared only in the VECTOR cycle that services it. Set and clear in the same cycle: set wins.
- **Candidate:** `new_lvl` = highest k+1 with `pending[k]`=1. Take the interrupt only if `new_lvl` > `cur_level`.
- **FSM states:** RUN, SAVE, VECTOR, RESTORE, WAIT, RESUME.
- **RUN → SAVE** when `insn_done` & `global_ie` & `new_lvl` > `cur_level` & !`eret`.
  - In SAVE (1 cycle): `stall`=1; assert exactly one strobe selected by `cur_level` (0 → `enable_userBackUp`, 1 → `enable_BackUp1`, 2 → `enable_BackUp2`).
  - Also `epc[cur_level]` ← `pc_next` (captured at RUN exit) and `prev_lvl[new_lvl]` ← `cur_level`. `new_lvl` is latched at RUN exit.
- **SAVE → VECTOR** (1 cycle): `stall`=1, `pc_load`=1, `pc_target`=VEC[new_lvl], `cur_level` ← new_lvl, clear the pending bit. Then go to RUN.
- **RUN + `insn_done` & `eret`:**
  - If `cur_level`=0: `err_eret`=1 for 1 cycle; stay in RUN.
  - Otherwise go to RESTORE with p = `prev_lvl[cur_level]`. In RESTORE (1 cycle): `stall`=1; assert the restore strobe for bank p (0 → user, 1 → BackUp1, 2 → BackUp2).
- **RESTORE → WAIT:** WAIT lasts `RESTORE_WAIT` cycles with `stall`=1; WAIT is skipped if the parameter is 0.
- **RESUME** (1 cycle): `stall`=1, `pc_load`=1, `pc_target`=`epc[p]`, `cur_level` ← p. Then go to RUN.
- **Latency:** entry is 2 stall cycles; return is 2+`RESTORE_WAIT` stall cycles.
- **Same-cycle `eret` and eligible interrupt:** `eret` wins. The interrupt stays pending and is re-evaluated after RESUME at the next `insn_done`.
- **Strobe exclusivity:** at most one of the six bank strobes is high in any cycle. Save and restore strobes never overlap.
- **Nesting:** strictly increasing levels, so each bank holds at most one live context. Equal or lower pending requests wait until `cur_level` drops below them.
- **`global_ie`=0:** blocks entry only; a sequence already in progress completes.

Decomposition:
- **Shared package `irq_pkg`:**
  - State enum.
  - Level constants `LVL_USER`=0 … `LVL_3`=3.
  - Bank-select encoding.
  - Function mapping level → one-hot strobe vector.
- **Sub-module `irq_prio_enc`:** edge detect, pending latch and priority encoder; outputs `new_lvl` and a valid flag.
- The top level holds the FSM, the EPC array and the `prev_lvl` array.

Test Plan:
- **Entry from user:** level 0, `global_ie`=1, pulse `irq_in[0]`, `insn_done` with `pc_next`=0x40.
  - SAVE: `enable_userBackUp` for 1 cycle.
  - VECTOR: `pc_load` with `pc_target`=0x1000; `cur_level`=1; `pending`=0.
- **Nesting and unwind:** at level 1, pulse `irq_in[2]` with `pc_next`=0x1008.
  - Entry: `enable_BackUp1`, then `pc_target`=0x1200, `cur_level`=3.
  - `eret`: `restore_BackUp1`, 1 WAIT cycle, then `pc_target`=0x1008, `cur_level`=1.
  - Second `eret`: `restore_userBackUp`, then `pc_target`=0x40, `cur_level`=0.
- **Priority and blocking:** at level 2, pulse `irq_in[0]` → no entry, `pending`=3'b001. After `eret` to level 0 and the next `insn_done` → level-1 entry.
- **Simultaneous:** at level 1, `eret` and `irq_in[1]` edge in the same `insn_done` cycle → restore sequence first. The next `insn_done` at level 0 → entry to level 2 saving the user bank.
- **Errors and gating:**
  - `eret` at level 0 → `err_eret` 1-cycle pulse, no strobes.
  - `global_ie`=0 with `pending`≠0 → no entry, `stall`=0.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT → all outputs 0 immediately, `cur_level`=0. After release, an `irq_in[1]` edge enters normally via `enable_userBackUp`.
